load_store_unit: RTL and testbench

//  MEM-stage load/store unit; sits between pipeline MEM stage and data_memory.

---
 rtl/load_store_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage load/store unit between the pipeline MEM stage and the
//            data memory. Maps RV32 load/store funct3 onto memory size codes,
//            range-checks every access against the data memory window, issues
//            only naturally aligned memory transactions and sign/zero-extends
//            load results.
// Options  : MISALIGN_SPLIT_EN - when defined, a misaligned access is carried
//            out as N single-byte transactions over N cycles, with the pipeline
//            stalled for the first N-1 of them. When undefined, a misaligned
//            access is rejected with a one-cycle misalign_err pulse.
// Ports    : clk, reset (synchronous, active-high)
//            req_valid/req_we/req_funct3/req_addr/req_wdata - MEM-stage request
//            stall       - hold MEM and earlier stages, keep req_* stable
//            load_valid/load_data - extended load result (data 0 when not valid)
//            misalign_err/access_fault - one-cycle rejection pulses
//            mem_addr/mem_wdata/mem_size/mem_wr_en/mem_rd_en - to data memory
//            mem_rdata   - combinational little-endian read data from memory
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        access_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Byte/half results come from the low lanes; funct3[2] selects zero-extension.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {{24{w[7]  & ~f3[2]}}, w[7:0]};
            2'b01:   r = {{16{w[15] & ~f3[2]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [2:0]  w_bytes;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic [32:0] w_offset;
    logic [32:0] w_end;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_bytes = 3'd1;
            2'b01:   w_bytes = 3'd2;
            default: w_bytes = 3'd4;
        endcase
    end

    assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                    || (req_we && req_funct3[2]);

    // Bit 32 of the offset is the borrow (address below the window). The end
    // is formed from the 32-bit offset so an address just below the base can
    // never wrap back into range.
    assign w_offset       = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign w_end          = {1'b0, w_offset[31:0]} + {30'd0, w_bytes};
    assign w_out_of_range = w_offset[32] || (w_end > 33'(MEM_BYTES));

    assign w_misaligned = ((w_bytes == 3'd2) && req_addr[0])
                       || ((w_bytes == 3'd4) && (req_addr[1:0] != 2'b00));

`ifdef MISALIGN_SPLIT_EN
    // ------------------------------------------------------------------
    // Split-transaction context: the request is captured on the first
    // cycle so req_* may change freely while stalled.
    // ------------------------------------------------------------------
    logic        lat_we_q, lat_we_d;
    logic [2:0]  lat_funct3_q, lat_funct3_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] buf_q, buf_d;          // load bytes 0..2 gathered so far

    logic [1:0]  w_last_idx;
    logic [7:0]  w_wbyte;
    logic [31:0] w_merged;

    // Only halves and words can be misaligned, so the last index is 1 or 3.
    assign w_last_idx = (lat_funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign w_wbyte    = 8'(lat_wdata_q >> {idx_q, 3'b000});
    assign w_merged   = (lat_funct3_q[1:0] == 2'b01)
                      ? {16'd0, mem_rdata[7:0], buf_q[7:0]}
                      : {mem_rdata[7:0], buf_q};
`endif

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        load_valid   = 1'b0;
        load_data    = 32'd0;
        misalign_err = 1'b0;
        access_fault = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        mem_size     = 3'b000;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        lat_we_d     = lat_we_q;
        lat_funct3_d = lat_funct3_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
`endif

        // Outputs are held quiet during reset so an in-flight split cannot
        // write another byte on the reset edge.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (w_illegal || w_out_of_range) begin
                            access_fault = 1'b1;
                        end else if (!w_misaligned) begin
                            mem_addr  = req_addr;
                            mem_wdata = req_wdata;
                            mem_size  = {1'b0, req_funct3[1:0]};
                            mem_wr_en = req_we;
                            mem_rd_en = !req_we;
                            if (!req_we) begin
                                load_valid = 1'b1;
                                load_data  = extend(req_funct3, mem_rdata);
                            end
                        end else begin
`ifdef MISALIGN_SPLIT_EN
                            mem_addr     = req_addr;
                            mem_wdata    = {24'd0, req_wdata[7:0]};
                            mem_wr_en    = req_we;
                            mem_rd_en    = !req_we;
                            stall        = 1'b1;
                            state_d      = SPLIT;
                            idx_d        = 2'd1;
                            lat_we_d     = req_we;
                            lat_funct3_d = req_funct3;
                            lat_addr_d   = req_addr;
                            lat_wdata_d  = req_wdata;
                            buf_d[7:0]   = mem_rdata[7:0];
`else
                            misalign_err = 1'b1;
`endif
                        end
                    end
                end

                SPLIT: begin
`ifdef MISALIGN_SPLIT_EN
                    mem_addr  = lat_addr_q + {30'd0, idx_q};
                    mem_wdata = {24'd0, w_wbyte};
                    mem_wr_en = lat_we_q;
                    mem_rd_en = !lat_we_q;
                    if (idx_q == w_last_idx) begin
                        state_d = IDLE;
                        if (!lat_we_q) begin
                            load_valid = 1'b1;
                            load_data  = extend(lat_funct3_q, w_merged);
                        end
                    end else begin
                        stall = 1'b1;
                        idx_d = idx_q + 2'd1;
                        case (idx_q)
                            2'd1:    buf_d[15:8]  = mem_rdata[7:0];
                            2'd2:    buf_d[23:16] = mem_rdata[7:0];
                            default: buf_d        = buf_q;
                        endcase
                    end
`else
                    // Unreachable without splitting; recover to IDLE.
                    state_d = IDLE;
`endif
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
`ifdef MISALIGN_SPLIT_EN
            lat_we_q     <= 1'b0;
            lat_funct3_q <= 3'b000;
            lat_addr_q   <= 32'd0;
            lat_wdata_q  <= 32'd0;
            idx_q        <= 2'd0;
            buf_q        <= 24'd0;
`endif
        end else begin
            state_q      <= state_d;
`ifdef MISALIGN_SPLIT_EN
            lat_we_q     <= lat_we_d;
            lat_funct3_q <= lat_funct3_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. A byte-array data memory
//            is attached to the memory port; a transaction-level reference
//            model with its own byte array predicts every result. Directed
//            table vectors, a reset-during-split sequence (split build only)
//            and randomized transactions are applied, then both memories are
//            compared byte by byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int unsigned MEM_BYTES = 256;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        access_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;

    load_store_unit #(
        .BASE_ADDR (BASE),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .access_fault (access_fault),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_size     (mem_size),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Data memory: combinational little-endian read, byte-lane write
    // ------------------------------------------------------------------
    logic [7:0] dmem [256];
    logic [7:0] ref_mem [256];
    logic       mem_init;
    logic [7:0] ma;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    assign ma        = 8'(mem_addr - BASE);
    assign mem_rdata = {dmem[ma + 8'd3], dmem[ma + 8'd2], dmem[ma + 8'd1], dmem[ma]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) dmem[i] <= pat(i);
        end else if (mem_wr_en) begin
            dmem[ma] <= mem_wdata[7:0];
            if (mem_size != 3'b000) dmem[ma + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 3'b010) begin
                dmem[ma + 8'd2] <= mem_wdata[23:16];
                dmem[ma + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: one whole access at a time, straight from the rules.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic e_fault, output logic e_mis,
                         output logic e_lv, output logic [31:0] e_ld, output int e_cyc);
        int     n;
        bit     illegal, oor, mis;
        longint off, val;
        n       = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
        off     = longint'(a) - longint'(BASE);
        oor     = (off < 0) || (off + n > MEM_BYTES);
        mis     = (a % n) != 0;
        e_fault = illegal || oor;
        e_mis   = !e_fault && mis && !SPLIT;
        e_cyc   = (!e_fault && mis && SPLIT) ? n : 1;
        e_lv    = 1'b0;
        e_ld    = 32'd0;
        if (!e_fault && !e_mis) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[off + i] = wd[8 * i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) val = val | (longint'(ref_mem[off + i]) << (8 * i));
                if (!f3[2] && n < 4 && val[8 * n - 1]) val = val - (longint'(1) << (8 * n));
                e_lv = 1'b1;
                e_ld = 32'(val);
            end
        end
    endtask

    // Drives one request until stall drops; req_* are scrambled while stalled.
    task automatic drive_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output int cyc, output int stl,
                             output logic fault, output logic mis, output logic lv,
                             output logic [31:0] ld, output logic en, output logic leak,
                             output logic idle_bad);
        logic busy;
        cyc = 0; stl = 0; fault = 0; mis = 0; lv = 0; ld = 0; en = 0; leak = 0; busy = 1;
        #2;
        idle_bad = stall | load_valid | access_fault | misalign_err | mem_wr_en | mem_rd_en;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (busy && cyc < 10) begin
            #2;
            cyc++;
            fault = fault | access_fault;
            mis   = mis | misalign_err;
            en    = en | mem_wr_en | mem_rd_en;
            if (load_valid) begin
                lv = 1'b1;
                ld = load_data;
            end else if (load_data != 32'd0) begin
                leak = 1'b1;
            end
            busy = stall;
            if (stall) stl++;
            @(negedge clk);
            if (busy) begin
                req_we     = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic run_and_check(input string nm, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic e_fault, input logic e_mis, input logic e_lv,
                                 input logic [31:0] e_ld, input int e_cyc);
        int          cyc, stl;
        logic        f, m, lv, en, leak, idle_bad;
        logic [31:0] ld;
        drive_txn(we, f3, a, wd, cyc, stl, f, m, lv, ld, en, leak, idle_bad);
        check({nm, " idle_quiet"},   32'(idle_bad), 32'd0);
        check({nm, " cycles"},       32'(cyc),      32'(e_cyc));
        check({nm, " stall_cycles"}, 32'(stl),      32'(e_cyc - 1));
        check({nm, " access_fault"}, 32'(f),        32'(e_fault));
        check({nm, " misalign_err"}, 32'(m),        32'(e_mis));
        check({nm, " load_valid"},   32'(lv),       32'(e_lv));
        check({nm, " load_data"},    ld,            e_ld);
        check({nm, " mem_enable"},   32'(en),       32'(!(e_fault || e_mis)));
        check({nm, " data_leak"},    32'(leak),     32'd0);
    endtask

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_fault;
        logic        e_mis;
        logic        e_lv;
        logic [31:0] e_ld;
        int          e_cyc;
    } vec_t;

    vec_t vq[$];

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        mf, mm, mlv;
        logic [31:0] mld, a;
        int          mcyc;
        logic [2:0]  legal_f3 [5];

        legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;

        // Reset with a live store request: everything must stay quiet.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = BASE + 32'h40; req_wdata = 32'h5A5A_5A5A;
        #2;
        check("reset stall",        32'(stall),        32'd0);
        check("reset load_valid",   32'(load_valid),   32'd0);
        check("reset load_data",    load_data,         32'd0);
        check("reset misalign_err", 32'(misalign_err), 32'd0);
        check("reset access_fault", 32'(access_fault), 32'd0);
        check("reset mem_wr_en",    32'(mem_wr_en),    32'd0);
        check("reset mem_rd_en",    32'(mem_rd_en),    32'd0);
        check("reset mem_addr",     mem_addr,          32'd0);
        check("reset mem_wdata",    mem_wdata,         32'd0);
        check("reset mem_size",     32'(mem_size),     32'd0);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;

        // Directed vectors (expected values written out by hand).
        vq.push_back(vec_t'{"SW_10",   1'b1, 3'b010, BASE + 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"LW_10",   1'b0, 3'b010, BASE + 32'h10, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 1});
        vq.push_back(vec_t'{"LB_13",   1'b0, 3'b000, BASE + 32'h13, 32'h0, 0, 0, 1, 32'hFFFF_FFDE, 1});
        vq.push_back(vec_t'{"LBU_13",  1'b0, 3'b100, BASE + 32'h13, 32'h0, 0, 0, 1, 32'h0000_00DE, 1});
        vq.push_back(vec_t'{"LH_12",   1'b0, 3'b001, BASE + 32'h12, 32'h0, 0, 0, 1, 32'hFFFF_DEAD, 1});
        vq.push_back(vec_t'{"LHU_12",  1'b0, 3'b101, BASE + 32'h12, 32'h0, 0, 0, 1, 32'h0000_DEAD, 1});
        vq.push_back(vec_t'{"SW_FC",   1'b1, 3'b010, BASE + 32'hFC, 32'hCAFE_F00D, 0, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"LW_FC",   1'b0, 3'b010, BASE + 32'hFC, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 1});
        vq.push_back(vec_t'{"LB_FF",   1'b0, 3'b000, BASE + 32'hFF, 32'h0, 0, 0, 1, 32'hFFFF_FFCA, 1});
        vq.push_back(vec_t'{"LW_FE",   1'b0, 3'b010, BASE + 32'hFE, 32'h0, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"LB_100",  1'b0, 3'b000, BASE + 32'h100, 32'h0, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"LW_below",1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"LW_wrap", 1'b0, 3'b010, 32'h7FFF_FFFF, 32'h0, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"SW_FD",   1'b1, 3'b010, BASE + 32'hFD, 32'h1234_5678, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"LH_FF",   1'b0, 3'b001, BASE + 32'hFF, 32'h0, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"SBU_ill", 1'b1, 3'b100, BASE + 32'h20, 32'h77, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"L011_ill",1'b0, 3'b011, BASE + 32'h20, 32'h0, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"L110_ill",1'b0, 3'b110, BASE + 32'h20, 32'h0, 1, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"SW_00",   1'b1, 3'b010, BASE, 32'h12F0_8056, 0, 0, 0, 32'h0, 1});
        vq.push_back(vec_t'{"LH_01",   1'b0, 3'b001, BASE + 32'h01, 32'h0,
                            0, !SPLIT, SPLIT, SPLIT ? 32'hFFFF_F080 : 32'h0, SPLIT ? 2 : 1});
        vq.push_back(vec_t'{"SW_21",   1'b1, 3'b010, BASE + 32'h21, 32'h1122_3344,
                            0, !SPLIT, 0, 32'h0, SPLIT ? 4 : 1});
        vq.push_back(vec_t'{"LW_21",   1'b0, 3'b010, BASE + 32'h21, 32'h0,
                            0, !SPLIT, SPLIT, SPLIT ? 32'h1122_3344 : 32'h0, SPLIT ? 4 : 1});
        vq.push_back(vec_t'{"LBU_21",  1'b0, 3'b100, BASE + 32'h21, 32'h0,
                            0, 0, 1, SPLIT ? 32'h44 : 32'hCA, 1});
        vq.push_back(vec_t'{"LBU_24",  1'b0, 3'b100, BASE + 32'h24, 32'h0,
                            0, 0, 1, SPLIT ? 32'h11 : 32'h39, 1});

        foreach (vq[k]) begin
            model(vq[k].we, vq[k].f3, vq[k].a, vq[k].wd, mf, mm, mlv, mld, mcyc);
            run_and_check(vq[k].nm, vq[k].we, vq[k].f3, vq[k].a, vq[k].wd,
                          vq[k].e_fault, vq[k].e_mis, vq[k].e_lv, vq[k].e_ld, vq[k].e_cyc);
        end

`ifdef MISALIGN_SPLIT_EN
        // Reset during the second cycle of a split store: only byte 0 lands.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = BASE + 32'h31; req_wdata = 32'hA1B2_C3D4;
        #2;
        check("rst_split stall_c0", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("rst_split wr_in_reset", 32'(mem_wr_en), 32'd0);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        #2;
        check("rst_split stall_after", 32'(stall), 32'd0);
        check("rst_split enables_after", 32'(mem_wr_en | mem_rd_en), 32'd0);
        ref_mem[8'h31] = 8'hD4;
        model(1'b0, 3'b010, BASE + 32'h30, 32'h0, mf, mm, mlv, mld, mcyc);
        run_and_check("rst_split LW_30", 1'b0, 3'b010, BASE + 32'h30, 32'h0, mf, mm, mlv, mld, mcyc);
`endif

        // Randomized transactions against the reference model.
        for (int t = 0; t < 300; t++) begin
            logic       we;
            logic [2:0] f3;
            logic [31:0] wd;
            we = 1'($urandom);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            wd = $urandom;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE - 32'($urandom_range(1, 4));
                2:       a = BASE + 32'(MEM_BYTES) - 32'($urandom_range(0, 4));
                default: a = BASE + 32'($urandom_range(0, 255));
            endcase
            model(we, f3, a, wd, mf, mm, mlv, mld, mcyc);
            run_and_check($sformatf("rnd%0d", t), we, f3, a, wd, mf, mm, mlv, mld, mcyc);
        end

        // Final memory image must match the model byte for byte.
        @(negedge clk);
        for (int i = 0; i < 256; i++)
            check($sformatf("mem[0x%02h]", i), 32'(dmem[i]), 32'(ref_mem[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
